// File: rtl/xt_hb_master_arbiter_if.sv
// xt_hb_master_arbiter_if: master-side requests and slave-side bus shared through the arbiter
interface xt_hb_master_arbiter_if #(
  parameter int MASTER_NUM = 3,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [MASTER_NUM-1:0] m_req;
  logic [MASTER_NUM-1:0] m_lock;
  logic [MASTER_NUM-1:0] m_we;
  logic [MASTER_NUM*ADDR_W-1:0] m_addr;
  logic [MASTER_NUM*DATA_W-1:0] m_wdata;
  logic [MASTER_NUM*DATA_W/8-1:0] m_wstrb;
  logic [MASTER_NUM-1:0] stall_req;
  logic [DATA_W-1:0] m_rdata;
  logic s_valid;
  logic s_we;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wdata;
  logic [DATA_W/8-1:0] s_wstrb;
  logic s_ready;
  logic [DATA_W-1:0] s_rdata;
  modport master (
    output m_req, m_lock, m_we, m_addr, m_wdata, m_wstrb, s_ready, s_rdata,
    input stall_req, m_rdata, s_valid, s_we, s_addr, s_wdata, s_wstrb
  );
  modport slave (
    input m_req, m_lock, m_we, m_addr, m_wdata, m_wstrb, s_ready, s_rdata,
    output stall_req, m_rdata, s_valid, s_we, s_addr, s_wdata, s_wstrb
  );
endinterface

// File: rtl/xt_hb_master_arbiter.sv
// xt_hb_master_arbiter: round-robin XT_HB master arbiter with lock and optional XT_HB_ARB_TIMEOUT_EN abort
module xt_hb_master_arbiter #(
  parameter int MASTER_NUM = 3,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MAX_HOLD = 8,
  parameter int TIMEOUT = 64
) (
  input logic clk,
  input logic rst_n,
  xt_hb_master_arbiter_if.slave bus,
  output logic [$clog2(MASTER_NUM)-1:0] grant_id,
  output logic busy
`ifdef XT_HB_ARB_TIMEOUT_EN
  ,
  output logic bus_err
`endif
);
  localparam int GW = $clog2(MASTER_NUM);
  typedef enum logic [1:0] {IDLE, ACCESS, LOCKED} state_t;
  state_t state, state_nxt;
  logic [GW-1:0] rr_ptr, pick, nxt_ptr;
  logic [7:0] hold_cnt;
  logic [DATA_W-1:0] rdata_q, rdata_now;
  logic done, lock_go, abort, release_lock;
`ifdef XT_HB_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_cnt;
  assign abort = state == ACCESS && !bus.s_ready && int'(to_cnt) == TIMEOUT - 1;
  assign bus_err = abort;
  // count consecutive ACCESS cycles without s_ready; cleared on any exit from ACCESS
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) to_cnt <= '0;
    else to_cnt <= (state == ACCESS && !bus.s_ready && !abort) ? to_cnt + 1'b1 : '0;
`else
  assign abort = 1'b0;
`endif
  assign done = state == ACCESS && (bus.s_ready || abort);
  assign lock_go = state == ACCESS && bus.s_ready && bus.m_lock[grant_id] && int'(hold_cnt) < MAX_HOLD - 1;
  assign release_lock = state == LOCKED && !bus.m_req[grant_id];
  assign nxt_ptr = grant_id == GW'(MASTER_NUM - 1) ? '0 : grant_id + 1'b1;
  assign rdata_now = abort ? DATA_W'(32'hDEADBEEF) : bus.s_rdata;
  // first requester at or after rr_ptr; scanned backwards so the nearest one wins
  always_comb begin
    pick = rr_ptr;
    for (int k = MASTER_NUM - 1; k >= 0; k--)
      if (bus.m_req[GW'((int'(rr_ptr) + k) % MASTER_NUM)]) pick = GW'((int'(rr_ptr) + k) % MASTER_NUM);
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  // next-state: a locked owner returns to ACCESS without re-arbitration
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = |bus.m_req ? ACCESS : IDLE;
      ACCESS: state_nxt = lock_go ? LOCKED : done ? IDLE : ACCESS;
      LOCKED: state_nxt = bus.m_req[grant_id] ? ACCESS : IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  // grant, rotation pointer, lock depth and read-data hold registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      grant_id <= '0;
      rr_ptr <= '0;
      hold_cnt <= '0;
      rdata_q <= '0;
    end else begin
      if (state == IDLE && |bus.m_req) grant_id <= pick;
      if (done) rdata_q <= rdata_now;
      if (lock_go) hold_cnt <= hold_cnt + 1'b1;
      else if (done || release_lock) begin
        hold_cnt <= '0;
        rr_ptr <= nxt_ptr;
      end
    end
  // slave-side mux and master-side stall/read data
  always_comb begin
    busy = state != IDLE;
    bus.s_valid = state == ACCESS;
    bus.s_we = bus.m_we[grant_id];
    bus.s_addr = bus.m_addr[grant_id*ADDR_W +: ADDR_W];
    bus.s_wdata = bus.m_wdata[grant_id*DATA_W +: DATA_W];
    bus.s_wstrb = bus.m_wstrb[grant_id*(DATA_W/8) +: DATA_W/8];
    bus.stall_req = bus.m_req & ~(done ? MASTER_NUM'(1) << grant_id : '0);
    bus.m_rdata = done ? rdata_now : rdata_q;
  end
endmodule

// File: tb/tb_xt_hb_master_arbiter.sv
// tb_xt_hb_master_arbiter: directed checks of arbitration, lock, release and reset behaviour
module tb_xt_hb_master_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] grant_id;
  logic busy;
`ifdef XT_HB_ARB_TIMEOUT_EN
  logic bus_err;
`endif
  int compared = 0;
  int mismatched = 0;
  xt_hb_master_arbiter_if #(.MASTER_NUM(3), .ADDR_W(32), .DATA_W(32)) bus ();
  xt_hb_master_arbiter #(.MASTER_NUM(3), .ADDR_W(32), .DATA_W(32), .MAX_HOLD(8), .TIMEOUT(64)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .grant_id(grant_id),
    .busy(busy)
`ifdef XT_HB_ARB_TIMEOUT_EN
    ,
    .bus_err(bus_err)
`endif
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required to have finished", $time);
    $fatal(1, "watchdog");
  end
  task automatic clear_inputs();
    bus.m_req = '0;
    bus.m_lock = '0;
    bus.m_we = '0;
    bus.m_addr = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000};
    bus.m_wdata = '0;
    bus.m_wstrb = '0;
    bus.s_ready = 1'b0;
    bus.s_rdata = '0;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #4 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask
  task automatic wait_valid();
    for (int c = 0; c < 32 && bus.s_valid !== 1'b1; c++) begin
      @(posedge clk);
      #2;
    end
  endtask
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  task automatic test_reset();
    clear_inputs();
    bus.m_req = 3'b101;
    @(posedge clk);
    #2;
    compared++; if (bus.stall_req !== 3'b101) begin mismatched++; $display("FAIL rst_stall got %b want 101", bus.stall_req); end
    compared++; if (bus.s_valid !== 1'b0) begin mismatched++; $display("FAIL rst_valid got %b want 0", bus.s_valid); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL rst_busy got %b want 0", busy); end
    compared++; if (grant_id !== 2'd0) begin mismatched++; $display("FAIL rst_grant got %0d want 0", grant_id); end
    compared++; if (bus.m_rdata !== 32'h0) begin mismatched++; $display("FAIL rst_rdata got %h want 0", bus.m_rdata); end
  endtask
  task automatic test_single_read();
    do_reset();
    bus.m_addr = {32'h0000_3000, 32'h0000_2000, 32'h0000_0100};
    bus.m_req = 3'b001;
    step();
    compared++; if (bus.s_valid !== 1'b1) begin mismatched++; $display("FAIL rd_valid got %b want 1", bus.s_valid); end
    compared++; if (bus.s_addr !== 32'h0000_0100) begin mismatched++; $display("FAIL rd_addr got %h want 00000100", bus.s_addr); end
    compared++; if (bus.s_we !== 1'b0) begin mismatched++; $display("FAIL rd_we got %b want 0", bus.s_we); end
    compared++; if (bus.stall_req !== 3'b001) begin mismatched++; $display("FAIL rd_stall_wait got %b want 001", bus.stall_req); end
    compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL rd_busy got %b want 1", busy); end
    step();
    compared++; if (bus.stall_req !== 3'b001) begin mismatched++; $display("FAIL rd_stall_wait2 got %b want 001", bus.stall_req); end
    bus.s_ready = 1'b1;
    bus.s_rdata = 32'h1234_5678;
    #1;
    compared++; if (bus.stall_req !== 3'b000) begin mismatched++; $display("FAIL rd_stall_done got %b want 000", bus.stall_req); end
    compared++; if (bus.m_rdata !== 32'h1234_5678) begin mismatched++; $display("FAIL rd_rdata got %h want 12345678", bus.m_rdata); end
    @(posedge clk);
    #1;
    bus.m_req = 3'b000;
    bus.s_ready = 1'b0;
    bus.s_rdata = 32'h0;
    #1;
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL rd_idle_busy got %b want 0", busy); end
    compared++; if (bus.s_valid !== 1'b0) begin mismatched++; $display("FAIL rd_idle_valid got %b want 0", bus.s_valid); end
    compared++; if (bus.m_rdata !== 32'h1234_5678) begin mismatched++; $display("FAIL rd_hold got %h want 12345678", bus.m_rdata); end
  endtask
  task automatic test_round_robin();
    logic [31:0] want_addr;
    logic [2:0] want_stall;
    do_reset();
    bus.m_req = 3'b111;
    bus.s_ready = 1'b1;
    bus.s_rdata = 32'h5555_0000;
    #1;
    for (int n = 0; n < 6; n++) begin
      wait_valid();
      want_addr = 32'h1000 * (n % 3 + 1);
      want_stall = 3'b111 & ~(3'b001 << (n % 3));
      compared++; if (bus.s_valid !== 1'b1) begin mismatched++; $display("FAIL rr_valid[%0d] got %b want 1", n, bus.s_valid); end
      compared++; if (grant_id !== 2'(n % 3)) begin mismatched++; $display("FAIL rr_grant[%0d] got %0d want %0d", n, grant_id, n % 3); end
      compared++; if (bus.s_addr !== want_addr) begin mismatched++; $display("FAIL rr_addr[%0d] got %h want %h", n, bus.s_addr, want_addr); end
      compared++; if (bus.stall_req !== want_stall) begin mismatched++; $display("FAIL rr_stall[%0d] got %b want %b", n, bus.stall_req, want_stall); end
      step();
    end
    clear_inputs();
    step();
  endtask
  task automatic test_lock();
    logic [1:0] want_g;
    do_reset();
    bus.m_lock = 3'b010;
    bus.m_we = 3'b010;
    bus.m_wdata = {32'h0, 32'hCAFE_0001, 32'h0};
    bus.m_wstrb = 12'h0A0;
    bus.m_req = 3'b010;
    bus.s_ready = 1'b1;
    #1;
    for (int b = 0; b < 10; b++) begin
      wait_valid();
      want_g = (b == 8) ? 2'd0 : 2'd1;
      compared++; if (bus.s_valid !== 1'b1) begin mismatched++; $display("FAIL lk_valid[%0d] got %b want 1", b, bus.s_valid); end
      compared++; if (grant_id !== want_g) begin mismatched++; $display("FAIL lk_grant[%0d] got %0d want %0d", b, grant_id, want_g); end
      if (want_g == 2'd1) begin
        compared++; if ({bus.s_we, bus.s_wstrb, bus.s_wdata} !== {1'b1, 4'hA, 32'hCAFE_0001}) begin mismatched++; $display("FAIL lk_wr[%0d] got %b %h %h want 1 a cafe0001", b, bus.s_we, bus.s_wstrb, bus.s_wdata); end
      end else begin
        compared++; if (bus.s_we !== 1'b0) begin mismatched++; $display("FAIL lk_m0_we got %b want 0", bus.s_we); end
      end
      if (b == 0) bus.m_req = 3'b011;
      step();
      if (b == 0) begin
        compared++; if ({bus.s_valid, busy, grant_id} !== {1'b0, 1'b1, 2'd1}) begin mismatched++; $display("FAIL lk_locked got valid=%b busy=%b grant=%0d want 0 1 1", bus.s_valid, busy, grant_id); end
      end
      if (b == 8) bus.m_req = 3'b010;
    end
    clear_inputs();
    repeat (2) step();
  endtask
  task automatic test_lock_release();
    do_reset();
    bus.m_lock = 3'b100;
    bus.m_req = 3'b100;
    bus.s_ready = 1'b1;
    #1;
    for (int b = 0; b < 3; b++) begin
      wait_valid();
      compared++; if (grant_id !== 2'd2 || bus.s_valid !== 1'b1) begin mismatched++; $display("FAIL rel_grant[%0d] got %0d/%b want 2/1", b, grant_id, bus.s_valid); end
      if (b == 0) bus.m_req = 3'b101;
      step();
    end
    compared++; if ({bus.s_valid, busy, grant_id} !== {1'b0, 1'b1, 2'd2}) begin mismatched++; $display("FAIL rel_locked got valid=%b busy=%b grant=%0d want 0 1 2", bus.s_valid, busy, grant_id); end
    bus.m_req = 3'b001;
    step();
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL rel_idle got busy=%b want 0", busy); end
    step();
    compared++; if (bus.s_valid !== 1'b1 || grant_id !== 2'd0) begin mismatched++; $display("FAIL rel_next got valid=%b grant=%0d want 1 0", bus.s_valid, grant_id); end
    clear_inputs();
    repeat (2) step();
  endtask
  task automatic test_reset_mid_access();
    do_reset();
    bus.m_req = 3'b011;
    bus.s_ready = 1'b1;
    bus.s_rdata = 32'hA5A5_A5A5;
    #1;
    wait_valid();
    compared++; if (grant_id !== 2'd0) begin mismatched++; $display("FAIL mid_first got %0d want 0", grant_id); end
    step();
    wait_valid();
    compared++; if (grant_id !== 2'd1) begin mismatched++; $display("FAIL mid_second got %0d want 1", grant_id); end
    bus.s_ready = 1'b0;
    #1;
    compared++; if (bus.stall_req !== 3'b011) begin mismatched++; $display("FAIL mid_stall got %b want 011", bus.stall_req); end
    #1 rst_n = 1'b0;
    #1;
    compared++; if (bus.s_valid !== 1'b0 || busy !== 1'b0) begin mismatched++; $display("FAIL mid_async got valid=%b busy=%b want 0 0", bus.s_valid, busy); end
    compared++; if (bus.m_rdata !== 32'h0 || grant_id !== 2'd0) begin mismatched++; $display("FAIL mid_clear got rdata=%h grant=%0d want 0 0", bus.m_rdata, grant_id); end
    compared++; if (bus.stall_req !== 3'b011) begin mismatched++; $display("FAIL mid_rst_stall got %b want 011", bus.stall_req); end
    repeat (2) @(posedge clk);
    #4 rst_n = 1'b1;
    step();
    compared++; if (bus.s_valid !== 1'b1 || grant_id !== 2'd0) begin mismatched++; $display("FAIL mid_fresh got valid=%b grant=%0d want 1 0", bus.s_valid, grant_id); end
    clear_inputs();
    repeat (2) step();
  endtask
  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_lock();
    test_lock_release();
    test_reset_mid_access();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
